// File: rtl/bank_shift_scheduler_if.sv
// Bus bundle for bank_shift_scheduler: snapshot inputs, frame handshake and the
// parallel shift-register drive (shift clock, latch strobe, data byte).
interface bank_shift_scheduler_if;
    logic [63:0] top_in;
    logic [63:0] bot_in;
    logic        start;
    logic        busy;
    logic        done;
    logic        clock;
    logic        latch;
    logic [7:0]  data;

    modport master (
        output top_in, bot_in, start,
        input  busy, done, clock, latch, data
    );

    modport slave (
        input  top_in, bot_in, start,
        output busy, done, clock, latch, data
    );
endinterface

// File: rtl/bank_shift_scheduler.sv
// Per-frame serialiser of the top/bottom drive vectors onto the 8-bit shift bus.
// Define BANK_BOT_EN to emit the bottom bank (16 bytes); otherwise top bank only (8 bytes).
module bank_shift_scheduler #(
    parameter int unsigned CLK_DIV      = 2,
    parameter int unsigned LATCH_CYCLES = 2
) (
    input logic                    clk,
    input logic                    rst_n,
    bank_shift_scheduler_if.slave  bus
);

`ifdef BANK_BOT_EN
    localparam int unsigned SnapW    = 128;
    localparam int unsigned NumBytes = 16;
`else
    localparam int unsigned SnapW    = 64;
    localparam int unsigned NumBytes = 8;
`endif
    localparam int unsigned PhW = $clog2(CLK_DIV) + 1;
    localparam int unsigned LtW = $clog2(LATCH_CYCLES) + 1;

    typedef enum logic [2:0] {StIdle, StSetup, StHigh, StLatch, StDone} state_e;

    state_e           state_q, state_d;
    logic [PhW-1:0]   phase_q, phase_d;
    logic [LtW-1:0]   lat_q, lat_d;
    logic [3:0]       idx_q, idx_d;
    logic [SnapW-1:0] snap_q, snap_d;
    logic [SnapW-1:0] snap_in;

`ifdef BANK_BOT_EN
    assign snap_in = {bus.bot_in, bus.top_in};
`else
    logic unused_bot;
    assign unused_bot = ^bus.bot_in;
    assign snap_in    = bus.top_in;
`endif

    logic phase_last, lat_last, byte_last, accept, advance;

    assign phase_last = (phase_q == PhW'(CLK_DIV - 1));
    assign lat_last   = (lat_q == LtW'(LATCH_CYCLES - 1));
    assign byte_last  = (idx_q == 4'(NumBytes - 1));
    assign accept     = ((state_q == StIdle) || (state_q == StDone)) && bus.start;
    assign advance    = (state_q == StHigh) && (state_d == StSetup);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (bus.start) state_d = StSetup;
            StSetup: if (phase_last) state_d = StHigh;
            StHigh:  if (phase_last) state_d = byte_last ? StLatch : StSetup;
            StLatch: if (lat_last) state_d = StDone;
            StDone:  state_d = bus.start ? StSetup : StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Counters restart on every state change so none of them ever wraps.
    always_comb begin
        phase_d = '0;
        lat_d   = '0;
        idx_d   = idx_q;
        snap_d  = snap_q;
        if ((state_d == state_q) && ((state_q == StSetup) || (state_q == StHigh))) begin
            phase_d = phase_q + PhW'(1);
        end
        if ((state_d == state_q) && (state_q == StLatch)) begin
            lat_d = lat_q + LtW'(1);
        end
        if (accept) begin
            snap_d = snap_in;
            idx_d  = '0;
        end else if (advance) begin
            snap_d = snap_q << 8;
            idx_d  = idx_q + 4'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase_q <= '0;
            lat_q   <= '0;
            idx_q   <= '0;
            snap_q  <= '0;
        end else begin
            phase_q <= phase_d;
            lat_q   <= lat_d;
            idx_q   <= idx_d;
            snap_q  <= snap_d;
        end
    end

    // Outputs decode registered state only; the current byte sits in the snapshot MSBs.
    always_comb begin
        bus.busy  = 1'b0;
        bus.done  = 1'b0;
        bus.clock = 1'b0;
        bus.latch = 1'b0;
        bus.data  = 8'h00;
        unique case (state_q)
            StSetup: begin
                bus.busy = 1'b1;
                bus.data = snap_q[SnapW-1 -: 8];
            end
            StHigh: begin
                bus.busy  = 1'b1;
                bus.clock = 1'b1;
                bus.data  = snap_q[SnapW-1 -: 8];
            end
            StLatch: begin
                bus.busy  = 1'b1;
                bus.latch = 1'b1;
            end
            StDone:  bus.done = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_bank_shift_scheduler.sv
// Directed bench for bank_shift_scheduler: table of frames plus reset, isolation,
// back-to-back and abort sequences. Honours BANK_BOT_EN like the design.
module tb_bank_shift_scheduler;
    localparam int CD = 2;
    localparam int LC = 2;
`ifdef BANK_BOT_EN
    localparam int NB = 16;
`else
    localparam int NB = 8;
`endif
    localparam int LatchFirst = 2 * CD * NB + 1;
    localparam int DoneCyc    = LatchFirst + LC;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    bank_shift_scheduler_if bus();

    bank_shift_scheduler #(
        .CLK_DIV      (CD),
        .LATCH_CYCLES (LC)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int passes = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    typedef struct {
        logic [63:0]  top;
        logic [63:0]  bot;
        logic [127:0] exp_bb;  // emitted byte stream with bottom bank enabled
        logic [63:0]  exp_t;   // emitted byte stream, top bank only
    } vec_t;

    function automatic logic [127:0] expected(input vec_t v);
        return (NB == 16) ? v.exp_bb : {v.exp_t, 64'h0};
    endfunction

    // Starts a frame and watches it for a bounded number of cycles.
    task automatic run_frame(input string tag, input logic [127:0] e, input int inj_cyc);
        int         edges;
        int         lfirst;
        int         llast;
        int         ndone;
        int         dcyc;
        logic       prev_clk;
        logic [7:0] got [16];
        edges = 0; lfirst = 0; llast = 0; ndone = 0; dcyc = 0; prev_clk = 1'b0;
        for (int i = 0; i < 16; i++) got[i] = 8'h00;
        bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        for (int c = 1; c <= DoneCyc + 8; c++) begin
            if (c == inj_cyc) begin
                bus.top_in = ~bus.top_in;
                bus.bot_in = ~bus.bot_in;
                bus.start  = 1'b1;
            end else begin
                bus.start = 1'b0;
            end
            if (bus.clock && !prev_clk) begin
                if (edges < 16) got[edges] = bus.data;
                edges++;
            end
            prev_clk = bus.clock;
            if (bus.latch) begin
                if (lfirst == 0) lfirst = c;
                llast = c;
            end
            if (bus.done) begin
                ndone++;
                if (dcyc == 0) dcyc = c;
            end
            if (c == 1) check({tag, " busy c1"}, 64'(bus.busy), 64'd1);
            if (c == DoneCyc) check({tag, " busy at done"}, 64'(bus.busy), 64'd0);
            @(posedge clk); #1;
        end
        bus.start = 1'b0;
        check({tag, " edges"}, 64'(edges), 64'(NB));
        for (int i = 0; i < NB; i++) begin
            check($sformatf("%s byte%0d", tag, i), 64'(got[i]), 64'(e[127 - 8 * i -: 8]));
        end
        check({tag, " latch first"}, 64'(lfirst), 64'(LatchFirst));
        check({tag, " latch last"}, 64'(llast), 64'(LatchFirst + LC - 1));
        check({tag, " done count"}, 64'(ndone), 64'd1);
        check({tag, " done cycle"}, 64'(dcyc), 64'(DoneCyc));
    endtask

    vec_t vecs [4];

    initial begin
        int d1;
        int d2;
        int bad;
        vecs[0] = '{64'h0123456789ABCDEF, 64'hFEDCBA9876543210,
                    128'hFEDCBA9876543210_0123456789ABCDEF, 64'h0123456789ABCDEF};
        vecs[1] = '{64'h0000000000000000, 64'hFFFFFFFFFFFFFFFF,
                    128'hFFFFFFFFFFFFFFFF_0000000000000000, 64'h0000000000000000};
        vecs[2] = '{64'hA5A5A5A55A5A5A5A, 64'h00FF00FF0F0F0F0F,
                    128'h00FF00FF0F0F0F0F_A5A5A5A55A5A5A5A, 64'hA5A5A5A55A5A5A5A};
        vecs[3] = '{64'h8000000000000001, 64'h1000000000000080,
                    128'h1000000000000080_8000000000000001, 64'h8000000000000001};

        // Reset held with start asserted: everything quiet.
        bus.top_in = vecs[0].top;
        bus.bot_in = vecs[0].bot;
        bus.start  = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            check("reset outputs", 64'({bus.busy, bus.done, bus.clock, bus.latch, bus.data}),
                  64'd0);
        end
        bus.start = 1'b0;
        rst_n     = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("idle after reset", 64'({bus.busy, bus.done, bus.clock, bus.latch, bus.data}),
              64'd0);

        // Table of single frames.
        for (int v = 0; v < 4; v++) begin
            bus.top_in = vecs[v].top;
            bus.bot_in = vecs[v].bot;
            run_frame($sformatf("vec%0d", v), expected(vecs[v]), -1);
        end

        // Isolation: inputs flipped and start pulsed at the start of byte 4.
        bus.top_in = vecs[0].top;
        bus.bot_in = vecs[0].bot;
        run_frame("isolate", expected(vecs[0]), 2 * CD * 4 + 1);
        bus.top_in = vecs[0].top;
        bus.bot_in = vecs[0].bot;

        // Back-to-back frames with start held high.
        d1 = 0; d2 = 0;
        bus.start = 1'b1;
        @(posedge clk); #1;
        for (int c = 1; c <= 3 * DoneCyc; c++) begin
            if (bus.done) begin
                if (d1 == 0) d1 = c;
                else if (d2 == 0) d2 = c;
            end
            if (d1 != 0 && c == d1 + 1) begin
                check("b2b restart busy", 64'(bus.busy), 64'd1);
                check("b2b restart data", 64'(bus.data), 64'(expected(vecs[0]) >> 120));
            end
            @(posedge clk); #1;
        end
        bus.start = 1'b0;
        check("b2b first done", 64'(d1), 64'(DoneCyc));
        check("b2b period", 64'(d2 - d1), 64'(DoneCyc));
        repeat (DoneCyc + 2) @(posedge clk);
        #1;
        check("b2b idle", 64'(bus.busy), 64'd0);

        // Abort mid byte 5 with an asynchronous reset.
        bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (2 * CD * 5 + 1) @(posedge clk);
        #1;
        check("abort pre data", 64'(bus.data), 64'(expected(vecs[0]) >> (127 - 47)) & 64'hFF);
        #2;
        rst_n = 1'b0;
        #1;
        check("abort async", 64'({bus.busy, bus.done, bus.clock, bus.latch, bus.data}), 64'd0);
        bad = 0;
        for (int i = 0; i < DoneCyc + 4; i++) begin
            @(posedge clk); #1;
            if (bus.latch || bus.done || bus.busy) bad++;
        end
        check("abort quiet", 64'(bad), 64'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        run_frame("post-abort", expected(vecs[0]), -1);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
